me_req_ctrl: RTL and testbench

//  Initiator side of the motion-estimation req/ack interface. On start it issues NUM_BLOCKS

---
 rtl/me_req_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_me_req_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_req_ctrl.sv
// ---------------------------------------------------------------------------
// me_req_ctrl
// Initiator side of the motion-estimation req/ack interface. One accepted
// start runs NUM_BLOCKS searches back to back. For each search the ME core's
// best candidate index (min_cnt) and SAD are captured. The index is split into
// (dy_idx, dx_idx) by repeated subtraction of RANGE. The signed motion vector
// is then presented on a valid/ready result stream.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               pulse to begin a batch; ignored while busy
//   busy                high from accepted start until the batch ends
//   done                one-cycle pulse on the cycle the batch ends
//   err_timeout         sticky ack-timeout flag, cleared by an accepted start
//   me_req / me_ack     4-phase request/acknowledge to the ME core
//   me_min_cnt          best candidate index = dy_idx*RANGE + dx_idx
//   me_min_sad          best SAD
//   res_valid/res_ready result stream handshake
//   res_blk             block index within the batch
//   res_mv_x, res_mv_y  signed motion vector (two's complement)
//   res_sad             captured SAD
//   res_err             captured index was out of range (mv forced to 0,0)
//   dbg_state           current FSM state
// ---------------------------------------------------------------------------
module me_req_ctrl #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  parameter int NUM_BLOCKS   = 4,
  parameter int TIMEOUT      = 65535,
  localparam int SAD_WIDTH   = $clog2(TB_LENGTH**2) + PE_OUT_WIDTH,
  localparam int RANGE       = SW_LENGTH - TB_LENGTH + 1,
  localparam int CNT_WIDTH   = $clog2(RANGE**2),
  localparam int MV_WIDTH    = $clog2(RANGE) + 1,
  localparam int BLK_WIDTH   = $clog2(NUM_BLOCKS) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [CNT_WIDTH-1:0] me_min_cnt,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BLK_WIDTH-1:0] res_blk,
  output logic [MV_WIDTH-1:0]  res_mv_x,
  output logic [MV_WIDTH-1:0]  res_mv_y,
  output logic [SAD_WIDTH-1:0] res_sad,
  output logic                 res_err,
  output logic [2:0]           dbg_state
);

  localparam int TMR_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] RANGE_C  = CNT_WIDTH'(RANGE);
  // One bit wider so RANGE**2 is representable even when it is a power of two.
  localparam logic [CNT_WIDTH:0]   RANGE_SQ = (CNT_WIDTH + 1)'(RANGE * RANGE);
  localparam logic [MV_WIDTH-1:0]  HALF_MV  = MV_WIDTH'((RANGE - 1) / 2);
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT - 1);
  localparam logic [BLK_WIDTH-1:0] BLK_LAST = BLK_WIDTH'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACKLO  = 3'd1,
    S_REQ    = 3'd2,
    S_DECODE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [BLK_WIDTH-1:0]   blk_q, blk_d;
  logic [TMR_WIDTH-1:0]   timer_q, timer_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [MV_WIDTH-1:0]    quot_q, quot_d;
  logic [SAD_WIDTH-1:0]   sad_q, sad_d;
  logic                   err_q, err_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [MV_WIDTH-1:0]    mv_x_q, mv_x_d;
  logic [MV_WIDTH-1:0]    mv_y_q, mv_y_d;
  logic                   done_c;

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    timer_d       = timer_q;
    rem_d         = rem_q;
    quot_d        = quot_q;
    sad_d         = sad_q;
    err_d         = err_q;
    err_timeout_d = err_timeout_q;
    mv_x_d        = mv_x_q;
    mv_y_d        = mv_y_q;
    done_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_timeout_d = 1'b0;
          blk_d         = '0;
          state_d       = S_ACKLO;
        end
      end

      // Return-to-zero phase: a held ack from the previous search must drop
      // before a new request, so one long ack is never captured twice.
      S_ACKLO: begin
        if (!me_ack) state_d = S_REQ;
      end

      S_REQ: begin
        if (me_ack) begin
          rem_d   = me_min_cnt;
          sad_d   = me_min_sad;
          err_d   = ({1'b0, me_min_cnt} >= RANGE_SQ);
          quot_d  = '0;
          timer_d = '0;
          state_d = S_DECODE;
        end else if (timer_q == TMR_LAST) begin
          err_timeout_d = 1'b1;
          done_c        = 1'b1;
          timer_d       = '0;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_WIDTH'(1);
        end
      end

      // Restoring divide by RANGE, one subtraction per cycle. Quotient is
      // dy_idx, remainder is dx_idx; both are re-centred by (RANGE-1)/2.
      S_DECODE: begin
        if (err_q) begin
          mv_x_d  = '0;
          mv_y_d  = '0;
          state_d = S_OUT;
        end else if (rem_q >= RANGE_C) begin
          rem_d  = rem_q - RANGE_C;
          quot_d = quot_q + MV_WIDTH'(1);
        end else begin
          mv_x_d  = rem_q[MV_WIDTH-1:0] - HALF_MV;
          mv_y_d  = quot_q - HALF_MV;
          state_d = S_OUT;
        end
      end

      // Result stream: res_valid is held with all res_* fields frozen until
      // the cycle where res_valid && res_ready; that cycle is the transfer.
      S_OUT: begin
        if (res_ready) begin
          if (blk_q == BLK_LAST) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            blk_d   = blk_q + BLK_WIDTH'(1);
            state_d = S_ACKLO;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      blk_q         <= '0;
      timer_q       <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      sad_q         <= '0;
      err_q         <= 1'b0;
      err_timeout_q <= 1'b0;
      mv_x_q        <= '0;
      mv_y_q        <= '0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      timer_q       <= timer_d;
      rem_q         <= rem_d;
      quot_q        <= quot_d;
      sad_q         <= sad_d;
      err_q         <= err_d;
      err_timeout_q <= err_timeout_d;
      mv_x_q        <= mv_x_d;
      mv_y_q        <= mv_y_d;
    end
  end

  // Status is decoded from the state register so reset clears it at once.
  assign me_req      = (state_q == S_REQ);
  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_OUT);
  assign done        = done_c;
  assign err_timeout = err_timeout_q;
  assign res_blk     = blk_q;
  assign res_mv_x    = mv_x_q;
  assign res_mv_y    = mv_y_q;
  assign res_sad     = sad_q;
  assign res_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_me_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_me_req_ctrl
// Drives batches into me_req_ctrl while acting as the ME core. Expected
// results come from an arithmetic model (index / RANGE, index % RANGE) and
// are queued at ack time; a negedge monitor compares every presented result.
// ---------------------------------------------------------------------------
module tb_me_req_ctrl;

  localparam int TB_LEN = 16;
  localparam int SW_LEN = 64;
  localparam int PE_W   = 8;
  localparam int NB     = 4;
  localparam int TO     = 100;
  localparam int SAD_W  = $clog2(TB_LEN**2) + PE_W;
  localparam int RANGE  = SW_LEN - TB_LEN + 1;
  localparam int CNT_W  = $clog2(RANGE**2);
  localparam int MV_W   = $clog2(RANGE) + 1;
  localparam int BLK_W  = $clog2(NB) + 1;
  localparam int HALF   = (RANGE - 1) / 2;
  localparam int RW     = BLK_W + 2 * MV_W + SAD_W + 1;

  // clock / reset and DUT signals
  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic             me_req;
  logic             me_ack;
  logic [CNT_W-1:0] me_min_cnt;
  logic [SAD_W-1:0] me_min_sad;
  logic             res_valid;
  logic             res_ready;
  logic [BLK_W-1:0] res_blk;
  logic [MV_W-1:0]  res_mv_x;
  logic [MV_W-1:0]  res_mv_y;
  logic [SAD_W-1:0] res_sad;
  logic             res_err;
  logic [2:0]       dbg_state;

  me_req_ctrl #(
    .TB_LENGTH(TB_LEN), .SW_LENGTH(SW_LEN), .PE_OUT_WIDTH(PE_W),
    .NUM_BLOCKS(NB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .me_req(me_req), .me_ack(me_ack),
    .me_min_cnt(me_min_cnt), .me_min_sad(me_min_sad),
    .res_valid(res_valid), .res_ready(res_ready), .res_blk(res_blk),
    .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_sad(res_sad),
    .res_err(res_err), .dbg_state(dbg_state)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int req_rise   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];  // expected cycle of each res_valid rise

  int dir_cnt[2][4] = '{'{0, 1200, 2400, 50}, '{2401, 4095, 48, 49}};
  int dir_sad[2][4] = '{'{100, 7, 65535, 1234}, '{5, 6, 0, 300}};

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input int blk, input int cnt, input int sad);
    int   mx, my;
    logic e;
    if (cnt >= RANGE * RANGE) begin
      e = 1'b1; mx = 0; my = 0;
    end else begin
      e = 1'b0;
      my = cnt / RANGE - HALF;
      mx = cnt % RANGE - HALF;
    end
    return {BLK_W'(blk), MV_W'(mx), MV_W'(my), SAD_W'(sad), e};
  endfunction

  function automatic int model_latency(input int cnt);
    return (cnt >= RANGE * RANGE) ? 2 : cnt / RANGE + 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_req   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_req   = 1'b0;
    end else begin
      if (res_valid) begin
        if (!prev_valid) begin
          if (lat_q.size() == 0) bound_fail("latency_unexpected_valid");
          else chk("latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
        if (exp_q.size() == 0) begin
          bound_fail("result_unexpected");
        end else begin
          chk("result", 64'({res_blk, res_mv_x, res_mv_y, res_sad, res_err}), 64'(exp_q[0]));
          if (res_ready) void'(exp_q.pop_front());
        end
        chk("req_quiet_in_out", 64'(me_req), 64'(0));
      end
      if (prev_valid && !prev_ready) chk("valid_held", 64'(res_valid), 64'(1));
      if (done) begin
        done_cnt++;
        chk("done_align",
            64'((res_valid && res_ready && res_blk == BLK_W'(NB - 1)) || (me_req && !me_ack)),
            64'(1));
      end
      if (me_req && !prev_req) req_rise++;
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_req   = me_req;
    end
  end

  // ---------------- result consumer ----------------
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(0, 3) != 0);
        default: res_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_me_req"}, 64'(me_req), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_res_fields"}, 64'({res_blk, res_mv_x, res_mv_y, res_sad, res_err}), 64'(0));
    chk({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (me_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_me_req");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_idle");
  endtask

  // row < 0 selects random indices; hold <= 0 selects random ack hold length.
  task automatic run_batch(input int mode, input int row, input int hold, input bit stall);
    int cnt, sad, h, d0, r0;
    bit ok;
    ready_mode = stall ? 2 : mode;
    d0 = done_cnt;
    r0 = req_rise;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("err_timeout_cleared", 64'(err_timeout), 64'(0));
    for (int b = 0; b < NB; b++) begin
      wait_req(ok);
      if (!ok) return;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (row >= 0) begin
        cnt = dir_cnt[row][b];
        sad = dir_sad[row][b];
      end else begin
        if ($urandom_range(0, 7) == 0) cnt = $urandom_range(RANGE * RANGE, 2**CNT_W - 1);
        else cnt = $urandom_range(0, RANGE * RANGE - 1);
        sad = $urandom_range(0, 2**SAD_W - 1);
      end
      @(posedge clk);
      #1;
      me_ack     = 1'b1;
      me_min_cnt = CNT_W'(cnt);
      me_min_sad = SAD_W'(sad);
      exp_q.push_back(model(b, cnt, sad));
      lat_q.push_back(cyc + model_latency(cnt));
      h = (hold > 0) ? hold : $urandom_range(1, 3);
      repeat (h) @(posedge clk);
      #1;
      me_ack     = 1'b0;
      me_min_cnt = CNT_W'($urandom_range(0, 2**CNT_W - 1));
      me_min_sad = SAD_W'($urandom_range(0, 2**SAD_W - 1));
      if (stall && b == 0) begin
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (res_valid) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) bound_fail("wait_res_valid");
        repeat (10) @(negedge clk);
        chk("stall_valid_still_high", 64'(res_valid), 64'(1));
        ready_mode = mode;
      end else if (b < NB - 1) begin
        // start while busy must not restart the batch
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    wait_idle();
    chk("done_once", 64'(done_cnt - d0), 64'(1));
    chk("req_per_block", 64'(req_rise - r0), 64'(NB));
    chk("scoreboard_empty", 64'(exp_q.size() + lat_q.size()), 64'(0));
  endtask

  task automatic timeout_test();
    int  t0;
    bit  ok;
    ready_mode = 0;
    pulse_start();
    wait_req(ok);
    if (!ok) return;
    t0 = cyc;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      bound_fail("wait_timeout_done");
      return;
    end
    chk("timeout_req_cycles", 64'(cyc - t0 + 1), 64'(TO));
    @(negedge clk);
    chk("timeout_err_set", 64'(err_timeout), 64'(1));
    chk("timeout_busy_low", 64'(busy), 64'(0));
    chk("timeout_req_low", 64'(me_req), 64'(0));
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", 64'(err_timeout), 64'(1));
  endtask

  task automatic reset_in_req_test();
    bit ok;
    ready_mode = 0;
    pulse_start();
    wait_req(ok);
    if (!ok) return;
    #2 rst_n = 1'b0;
    #1 check_zero("rst_in_req");
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    me_ack     = 1'b0;
    me_min_cnt = '0;
    me_min_sad = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    run_batch(0, 0, 3, 1'b0);
    run_batch(0, 1, 1, 1'b0);
    for (int i = 0; i < 6; i++) run_batch(1, -1, 0, 1'b0);
    run_batch(1, -1, 0, 1'b1);
    timeout_test();
    run_batch(0, -1, 0, 1'b0);
    reset_in_req_test();
    run_batch(1, -1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
